disp_line_streamer: RTL and testbench
=====================================

Name: disp_line_streamer

Overview:
- Line-timing stream source for the post-processing pipeline.
- Reads left/right disparity pixels from a synchronous frame memory and emits them as valid-framed raster lines, with programmable horizontal blanking before each line.
- Drives the post-processing valid/disp_L/disp_R inputs; it is the hardware transmitter for that receiver interface.

Parameters:
- WIDTH, 9, disparity pixel width in bits.
- AWIDTH, 19, frame-memory address width; addresses wrap modulo 2^AWIDTH.
- CNTW, 11, width of the column, row and blanking counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle frame request; accepted only in IDLE.
- width  in  CNTW  active pixels per line; latched on an accepted start.
- height  in  CNTW  lines per frame; latched on an accepted start.
- hblank  in  CNTW  blanking cycles before every line; latched on an accepted start.
- base_addr  in  AWIDTH  address of the first pixel; latched on an accepted start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  AWIDTH  memory read address.
- rd_data_L  in  WIDTH  left pixel, valid 1 cycle after rd_en.
- rd_data_R  in  WIDTH  right pixel, valid 1 cycle after rd_en.
- valid_L  out  1  left pixel valid; always identical to valid_R.
- valid_R  out  1  right pixel valid.
- disp_L  out  WIDTH  left pixel output.
- disp_R  out  WIDTH  right pixel output.
- sol  out  1  first pixel of a line.
- eol  out  1  last pixel of a line.
- sof  out  1  first pixel of the frame.
- eof  out  1  last pixel of the frame.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and all counters are 0. A reset asserted mid-frame abandons the frame with no done pulse; outputs are 0 on the next cycle.
- FSM states: IDLE, BLANK, ACTIVE, DRAIN.
- IDLE:
  - start with width≠0 and height≠0 → BLANK; configuration is latched and busy=1.
  - start with width=0 or height=0 → DRAIN; no pixels are emitted.
  - start while not in IDLE is ignored.
- BLANK: counts exactly hblank cycles, then → ACTIVE. With hblank=0 it passes straight to ACTIVE with no blank cycle. rd_en=0 throughout.
- ACTIVE:
  - rd_en=1 for exactly width consecutive cycles.
  - rd_addr starts at base_addr and increments by 1 per read, continuing across lines with no gap.
  - After the last column: if lines remain → BLANK; otherwise → DRAIN.
- DRAIN: waits until the output pipeline is empty, then pulses done for 1 cycle, drops busy and → IDLE.
- Timing: no blanking follows the last line.
- Latency: a read issued in cycle t produces registered valid_L/R, disp_L/R and the flags in cycle t+2. valid is high for width contiguous cycles per line and low during blanking.
- Flags:
  - sol: first pixel of each line.
  - eol: last pixel of each line.
  - sof: sol of line 0.
  - eof: eol of the last line.
  - With width=1, sol and eol are asserted together.
- done: asserted in the cycle after eof. For an empty frame it is asserted 1 cycle after the DRAIN entry.
- disp_L and disp_R hold their last value while valid=0.
- Address arithmetic wraps modulo 2^AWIDTH with no error indication.

Optional Feature:
- Macro: DISP_SUBPIX_EN.
- Defined: disp_X = {rd_data_X[WIDTH-2:0], 1'b0}, i.e. integer disparity converted to 1-bit sub-pixel format as the post-processing input expects.
- Undefined: disp_X = rd_data_X unmodified.
- Timing and flags are identical in both builds.

Test Plan:
- width=640, height=2, hblank=21, base_addr=0, memory holds addr&0xFF:
  - 21 blank cycles, then 640 valid cycles with disp_L = 0..255 repeating, then 21 blank, then 640 valid.
  - sof once, eof once, done exactly 1 cycle after eof.
- width=1, height=3, hblank=0: three valid cycles each with sol=eol=1, back-to-back reads to addresses 0,1,2.
- width=0, height=5, start: no rd_en and no valid; done 1 cycle after DRAIN entry; busy high for exactly 2 cycles.
- base_addr=2^19-2, width=4, height=1: rd_addr sequence 524286, 524287, 0, 1.
- rst asserted at pixel 100 of line 0: next cycle all outputs 0 and no done. A new start after rst deassert begins a clean frame at base_addr.
- DISP_SUBPIX_EN defined, rd_data_L=9'h07F: disp_L=9'h0FE. Macro undefined: disp_L=9'h07F. Second start mid-frame is ignored in both builds.

Source files
------------

// File: rtl/disp_line_streamer_if.sv
// Pixel stream interface between the line streamer and the post-processing receiver.
interface disp_line_streamer_if #(
  parameter int WIDTH = 9
);
  logic             valid_L;
  logic             valid_R;
  logic [WIDTH-1:0] disp_L;
  logic [WIDTH-1:0] disp_R;
  logic             sol;
  logic             eol;
  logic             sof;
  logic             eof;

  modport master (output valid_L, valid_R, disp_L, disp_R, sol, eol, sof, eof);
  modport slave  (input  valid_L, valid_R, disp_L, disp_R, sol, eol, sof, eof);
endinterface

// File: rtl/disp_line_streamer.sv
// Frame-memory reader emitting valid-framed disparity raster lines with per-line blanking.
// Optional build macro DISP_SUBPIX_EN: shift pixels left by one into sub-pixel format.
module disp_line_streamer #(
  parameter int WIDTH  = 9,
  parameter int AWIDTH = 19,
  parameter int CNTW   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNTW-1:0]   width,
  input  logic [CNTW-1:0]   height,
  input  logic [CNTW-1:0]   hblank,
  input  logic [AWIDTH-1:0] base_addr,
  output logic              rd_en,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data_L,
  input  logic [WIDTH-1:0]  rd_data_R,
  disp_line_streamer_if.master px,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   wid_q, wid_d, hgt_q, hgt_d, hbl_q, hbl_d;
  logic [CNTW-1:0]   col_q, col_d, row_q, row_d, blk_q, blk_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_flags_q, s1_flags_d;   // {sof, eof, sol, eol}
  logic              valid_q, valid_d;
  logic [3:0]        flags_q, flags_d;
  logic [WIDTH-1:0]  disp_l_q, disp_l_d, disp_r_q, disp_r_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]  pix_l, pix_r;
  logic              last_col, last_row;

`ifdef DISP_SUBPIX_EN
  assign pix_l = rd_data_L << 1;
  assign pix_r = rd_data_R << 1;
`else
  assign pix_l = rd_data_L;
  assign pix_r = rd_data_R;
`endif

  assign last_col = (col_q == wid_q - CNTW'(1));
  assign last_row = (row_q == hgt_q - CNTW'(1));

  always_comb begin
    state_d    = state_q;
    wid_d      = wid_q;
    hgt_d      = hgt_q;
    hbl_d      = hbl_q;
    col_d      = col_q;
    row_d      = row_q;
    blk_d      = blk_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    busy_d     = busy_q & ~done_q;
    // Flags are tagged at read time and travel alongside the memory latency.
    s1_valid_d = rd_en_q;
    s1_flags_d = rd_en_q ? {last_row ? 1'b0 : 1'b0, 1'b0, 1'b0, 1'b0} : 4'b0;
    if (rd_en_q) begin
      s1_flags_d = {(col_q == '0) && (row_q == '0), last_col && last_row,
                    (col_q == '0), last_col};
    end
    valid_d  = s1_valid_q;
    flags_d  = s1_flags_q;
    disp_l_d = s1_valid_q ? pix_l : disp_l_q;
    disp_r_d = s1_valid_q ? pix_r : disp_r_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          wid_d  = width;
          hgt_d  = height;
          hbl_d  = hblank;
          addr_d = base_addr;
          col_d  = '0;
          row_d  = '0;
          blk_d  = '0;
          busy_d = 1'b1;
          if (width == '0 || height == '0) state_d = DRAIN;
          else if (hblank == '0)           state_d = ACTIVE;
          else                             state_d = BLANK;
        end
      end
      BLANK: begin
        if (blk_q == hbl_q - CNTW'(1)) begin
          blk_d   = '0;
          state_d = ACTIVE;
        end else begin
          blk_d = blk_q + CNTW'(1);
        end
      end
      ACTIVE: begin
        addr_d = addr_q + AWIDTH'(1);
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            state_d = DRAIN;
          end else begin
            row_d   = row_q + CNTW'(1);
            state_d = (hbl_q == '0) ? ACTIVE : BLANK;
          end
        end else begin
          col_d = col_q + CNTW'(1);
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wid_q      <= '0;
      hgt_q      <= '0;
      hbl_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      blk_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_flags_q <= '0;
      valid_q    <= 1'b0;
      flags_q    <= '0;
      disp_l_q   <= '0;
      disp_r_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wid_q      <= wid_d;
      hgt_q      <= hgt_d;
      hbl_q      <= hbl_d;
      col_q      <= col_d;
      row_q      <= row_d;
      blk_q      <= blk_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      s1_valid_q <= s1_valid_d;
      s1_flags_q <= s1_flags_d;
      valid_q    <= valid_d;
      flags_q    <= flags_d;
      disp_l_q   <= disp_l_d;
      disp_r_q   <= disp_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = addr_q;
  assign px.valid_L = valid_q;
  assign px.valid_R = valid_q;
  assign px.disp_L  = disp_l_q;
  assign px.disp_R  = disp_r_q;
  assign px.sof     = flags_q[3];
  assign px.eof     = flags_q[2];
  assign px.sol     = flags_q[1];
  assign px.eol     = flags_q[0];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_disp_line_streamer.sv
// Scoreboard bench for disp_line_streamer: frame model queues expected reads, pixels and done.
module tb_disp_line_streamer;
  localparam int WIDTH  = 9;
  localparam int AWIDTH = 19;
  localparam int CNTW   = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNTW-1:0]   width = '0, height = '0, hblank = '0;
  logic [AWIDTH-1:0] base_addr = '0;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data_L = '0, rd_data_R = '0;
  logic              busy, done;

  disp_line_streamer_if #(.WIDTH(WIDTH)) px_if ();

  disp_line_streamer #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .hblank(hblank), .base_addr(base_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_L(rd_data_L), .rd_data_R(rd_data_R), .px(px_if),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; int l; int r; logic sol, eol, sof, eof; } px_t;

  rd_t rd_q[$];
  px_t px_q[$];
  int  done_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_l = 0, last_r = 0;
  rd_t re;
  px_t pe;
  int  de;

  function automatic int mem_l(int a); return a & 'hFF; endfunction
  function automatic int mem_r(int a); return (a * 3 + 5) & 'h1FF; endfunction
  function automatic int exp_pix(int v);
`ifdef DISP_SUBPIX_EN
    return (v * 2) & 'h1FF;
`else
    return v;
`endif
  endfunction

  // Synchronous frame memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_L <= WIDTH'(mem_l(int'(rd_addr)));
      rd_data_R <= WIDTH'(mem_r(int'(rd_addr)));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got read addr %0d at cycle %0d, required no read", rd_addr, cyc);
        end else begin
          re = rd_q.pop_front();
          if (re.cyc != cyc || re.addr != int'(rd_addr)) begin
            errors++;
            $display("FAIL rd_seq: got addr %0d at cycle %0d, required addr %0d at cycle %0d",
                     rd_addr, cyc, re.addr, re.cyc);
          end
        end
      end
      if (px_if.valid_L || px_if.valid_R) begin
        checks++;
        if (px_q.size() == 0) begin
          errors++;
          $display("FAIL px_unexpected: got valid L/R %b%b at cycle %0d, required none",
                   px_if.valid_L, px_if.valid_R, cyc);
        end else begin
          pe = px_q.pop_front();
          last_l = pe.l;
          last_r = pe.r;
          if (!(px_if.valid_L && px_if.valid_R) || pe.cyc != cyc ||
              int'(px_if.disp_L) != pe.l || int'(px_if.disp_R) != pe.r ||
              {px_if.sol, px_if.eol, px_if.sof, px_if.eof} != {pe.sol, pe.eol, pe.sof, pe.eof}) begin
            errors++;
            $display("FAIL pixel: got cyc=%0d vL=%b vR=%b L=%0d R=%0d sol/eol/sof/eof=%b%b%b%b, required cyc=%0d L=%0d R=%0d flags=%b%b%b%b",
                     cyc, px_if.valid_L, px_if.valid_R, px_if.disp_L, px_if.disp_R,
                     px_if.sol, px_if.eol, px_if.sof, px_if.eof,
                     pe.cyc, pe.l, pe.r, pe.sol, pe.eol, pe.sof, pe.eof);
          end
        end
      end else begin
        checks++;
        if (int'(px_if.disp_L) != last_l || int'(px_if.disp_R) != last_r) begin
          errors++;
          $display("FAIL disp_hold: got L=%0d R=%0d at cycle %0d, required L=%0d R=%0d",
                   px_if.disp_L, px_if.disp_R, cyc, last_l, last_r);
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
        end else begin
          de = done_q.pop_front();
          if (de != cyc || !busy) begin
            errors++;
            $display("FAIL done_timing: got done at cycle %0d busy=%b, required cycle %0d busy=1",
                     cyc, busy, de);
          end
        end
      end
    end
  end

  task automatic flush();
    rd_q.delete();
    px_q.delete();
    done_q.delete();
    last_l = 0;
    last_r = 0;
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] snap;
    snap = {rd_en, rd_addr, px_if.valid_L, px_if.valid_R, px_if.disp_L, px_if.disp_R,
            px_if.sol, px_if.eol, px_if.sof, px_if.eof, busy, done};
    checks++;
    if (snap != '0) begin
      errors++;
      $display("FAIL %s: got outputs 0x%0h, required 0", name, snap);
    end
  endtask

  task automatic check_busy(input string name, input logic want);
    checks++;
    if (busy !== want) begin
      errors++;
      $display("FAIL %s: got busy=%b at cycle %0d, required %b", name, busy, cyc, want);
    end
  endtask

  // poke: cycle offset at which to pulse an extra start; rst_at: offset to assert reset.
  task automatic run_frame(input int w, input int h, input int hb, input int base,
                           input int poke, input int rst_at);
    int s, d, rc, a;
    rd_t rr;
    px_t pp;
    @(posedge clk); #1;
    s = cyc;
    width = CNTW'(w); height = CNTW'(h); hblank = CNTW'(hb); base_addr = AWIDTH'(base);
    start = 1'b1;
    if (w == 0 || h == 0) begin
      d = s + 2;
    end else begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          rc = s + 1 + r * (hb + w) + hb + c;
          a  = (base + r * w + c) % (1 << AWIDTH);
          rr.cyc = rc; rr.addr = a;
          rd_q.push_back(rr);
          pp.cyc = rc + 2;
          pp.l = exp_pix(mem_l(a));
          pp.r = exp_pix(mem_r(a));
          pp.sol = (c == 0);
          pp.eol = (c == w - 1);
          pp.sof = (c == 0) && (r == 0);
          pp.eof = (c == w - 1) && (r == h - 1);
          px_q.push_back(pp);
        end
      end
      d = s + 1 + (h - 1) * (hb + w) + hb + w - 1 + 3;
    end
    done_q.push_back(d);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_busy("busy_after_start", 1'b1);
    forever begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_q.size() == 0) break;
      if (cyc - s == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush();
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        repeat (12) @(posedge clk);
        return;
      end
      if (cyc - s == poke && cyc < d) begin
        start = 1'b1;
        width = CNTW'($urandom_range(1, 9));
        height = CNTW'($urandom_range(1, 3));
        hblank = CNTW'($urandom_range(0, 3));
        base_addr = AWIDTH'($urandom_range(0, (1 << AWIDTH) - 1));
      end
      if (cyc > d + 20) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got no done by cycle %0d, required done at cycle %0d", cyc, d);
        flush();
        return;
      end
    end
    @(negedge clk);
    check_busy("busy_after_done", 1'b0);
  endtask

  initial begin
    int w, h, hb, poke;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");

    run_frame(640, 2, 21, 0, -1, -1);
    run_frame(1, 3, 0, 0, -1, -1);
    run_frame(0, 5, 3, 0, -1, -1);
    run_frame(4, 1, 2, (1 << AWIDTH) - 2, -1, -1);
    run_frame(640, 2, 21, 0, -1, 124);
    run_frame(5, 2, 1, 0, -1, -1);
    run_frame(6, 3, 2, 100, 5, -1);
    run_frame(3, 2, 0, 7, 3, -1);

    for (int i = 0; i < 14; i++) begin
      w  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      h  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      hb = $urandom_range(0, 4);
      poke = $urandom_range(0, 1) ? $urandom_range(2, 15) : -1;
      run_frame(w, h, hb, $urandom_range(0, (1 << AWIDTH) - 1), poke, -1);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
